wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; all state cleared immediately.
REQ-004 in_valid  input  1  EX/MEM presents an instruction.
REQ-005 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-006 wb_ctrl_in  input  wb_control_t  MemtoReg[1:0], RegWrite of the offered instruction.
REQ-007 rd_addr_in  input  5  destination register.
REQ-008 alu_result, pc_plus4, imm  input  32 each  writeback candidates.
REQ-009 fun3  input  3  load width/sign; addr_lo  input  2  byte offset of the load address.
REQ-010 flush  input  1  kill held/pending instruction.
REQ-011 dmem_rvalid  input  1  data-memory read response valid; dmem_rdata  input  32  response data.
REQ-012 reg_write  output  1  register-file write enable toward the ID stage.
REQ-013 rd_addr  output  5; rd_data  output  32  register-file write address/data.
REQ-014 retired_count  output  CNT_W  count of reg_write pulses.

Function
REQ-015 FSM states: IDLE, WAIT_MEM; in_ready = (state == IDLE).
REQ-016 IDLE, accept with MemtoReg != MEM: next cycle reg_write = RegWrite && rd_addr_in != 0, rd_data selected (00 ALU, 10 PC+4, 11 imm); latency exactly 1.
REQ-017 IDLE, accept with MemtoReg == MEM: capture rd_addr, fun3, addr_lo, RegWrite; go WAIT_MEM; reg_write = 0.
REQ-018 WAIT_MEM, dmem_rvalid = 1: capture aligned load data; reg_write asserted the following cycle; return to IDLE that same edge.
REQ-019 dmem_rvalid while in IDLE is ignored; it never produces a write.
REQ-020 reg_write, rd_addr, rd_data are registered; reg_write is a single-cycle pulse per retired instruction.
REQ-021 Writes to x0 are suppressed (reg_write = 0) and not counted.
REQ-022 flush in WAIT_MEM: return to IDLE, discard the load; flush wins over a simultaneous dmem_rvalid.
REQ-023 flush in IDLE: a same-cycle accept is dropped and no write is produced; an already-registered write pulse still completes.
REQ-024 retired_count increments by 1 per reg_write pulse and wraps from all-ones to 0.
REQ-025 rd_data holds its last value when reg_write = 0.

Reset
REQ-026 On reset: state IDLE, reg_write 0, rd_addr 0, rd_data 0, retired_count 0, pending load discarded.
REQ-027 Reset mid-WAIT_MEM: a response arriving after reset deasserts is ignored per REQ-019.

Configuration
REQ-028 LOAD_ALIGN_EN defined: fun3 000/001/010/100/101 give LB/LH/LW/LBU/LHU, byte/half lane selected by addr_lo, sign/zero-extended.
REQ-029 LOAD_ALIGN_EN undefined: load data = dmem_rdata unchanged regardless of fun3/addr_lo; the load_align sub-module is not instantiated.

Structure
REQ-030 wb_control_t and MemtoReg encodings (MTR_ALU=00, MTR_MEM=01, MTR_PC4=10, MTR_IMM=11) live in the shared control-signal package; no local redefinition.
REQ-031 One sub-module, load_align (combinational; fun3, addr_lo, rdata in; 32-bit data out).

Verification
REQ-032 Accept ALU op rd=5, alu_result=0x0000_1234 -> next cycle reg_write=1, rd_addr=5, rd_data=0x0000_1234, retired_count=1.
REQ-033 Accept LW rd=7; dmem_rvalid after 3 cycles, rdata=0xDEAD_BEEF -> in_ready=0 while waiting; reg_write=1, rd_data=0xDEAD_BEEF one cycle after rvalid.
REQ-034 LOAD_ALIGN_EN: LB addr_lo=3, rdata=0x80xx_xxxx -> rd_data=0xFFFF_FF80; LHU addr_lo=2, rdata=0xBEEF_0000 -> 0x0000_BEEF.
REQ-035 Accept MemtoReg=PC+4 with rd=0, pc_plus4=0x104 -> reg_write stays 0, retired_count unchanged.
REQ-036 Load pending, flush and dmem_rvalid in the same cycle -> no write, state IDLE, in_ready=1 next cycle.
REQ-037 Reset asserted mid-WAIT_MEM, then rvalid after release -> outputs stay 0; preload retired_count=all-ones, one write -> wraps to 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared writeback control-signal package: MemtoReg encodings, the
// wb_control_t bundle, the stage FSM states and load funct3 codes.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10,
        MTR_IMM = 2'b11
    } mem_to_reg_e;

    typedef struct packed {
        mem_to_reg_e mem_to_reg;
        logic        reg_write;
    } wb_control_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: selects the byte/half lane addressed by addr_lo
// and sign- or zero-extends it according to the load funct3.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]  fun3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (fun3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/PC+4/immediate results after one cycle and loads
// after the data-memory response. Build macro LOAD_ALIGN_EN enables load_align.
//
// state    | meaning
// IDLE     | ready for a new instruction from EX/MEM
// WAIT_MEM | load accepted, waiting for dmem_rvalid (or flush)
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  wb_control_t      wb_ctrl_in,
    input  logic [4:0]       rd_addr_in,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      imm,
    input  logic [2:0]       fun3,
    input  logic [1:0]       addr_lo,
    input  logic             flush,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             reg_write,
    output logic [4:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic [CNT_W-1:0] retired_count
);

    wb_state_e   state, state_nxt;
    logic        wr_nxt;
    logic [4:0]  addr_nxt;
    logic [31:0] data_nxt;
    logic        capture;
    logic [4:0]  pend_rd;
    logic        pend_we;
    logic [31:0] load_data;

`ifdef LOAD_ALIGN_EN
    logic [2:0] pend_fun3;
    logic [1:0] pend_addr_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_fun3    <= 3'b0;
            pend_addr_lo <= 2'b0;
        end else if (capture) begin
            pend_fun3    <= fun3;
            pend_addr_lo <= addr_lo;
        end
    end

    load_align u_load_align (
        .fun3    (pend_fun3),
        .addr_lo (pend_addr_lo),
        .rdata   (dmem_rdata),
        .data    (load_data)
    );
`else
    // Without alignment the load width fields are don't-care.
    logic unused_load_cfg;
    assign unused_load_cfg = ^{fun3, addr_lo};
    assign load_data       = dmem_rdata;
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
        addr_nxt  = 5'b0;
        data_nxt  = 32'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // flush drops a same-cycle offer before it is taken
                if (in_valid && !flush) begin
                    if (wb_ctrl_in.mem_to_reg == MTR_MEM) begin
                        capture   = 1'b1;
                        state_nxt = WAIT_MEM;
                    end else begin
                        wr_nxt   = wb_ctrl_in.reg_write && (rd_addr_in != 5'd0);
                        addr_nxt = rd_addr_in;
                        case (wb_ctrl_in.mem_to_reg)
                            MTR_PC4: data_nxt = pc_plus4;
                            MTR_IMM: data_nxt = imm;
                            default: data_nxt = alu_result;
                        endcase
                    end
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (dmem_rvalid) begin
                    state_nxt = IDLE;
                    wr_nxt    = pend_we && (pend_rd != 5'd0);
                    addr_nxt  = pend_rd;
                    data_nxt  = load_data;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_rd <= 5'b0;
            pend_we <= 1'b0;
        end else if (capture) begin
            pend_rd <= rd_addr_in;
            pend_we <= wb_ctrl_in.reg_write;
        end
    end

    // Address/data only move on a real write so they hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write     <= 1'b0;
            rd_addr       <= 5'b0;
            rd_data       <= 32'b0;
            retired_count <= '0;
        end else begin
            reg_write <= wr_nxt;
            if (wr_nxt) begin
                rd_addr       <= addr_nxt;
                rd_data       <= data_nxt;
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with hand-computed expectations.
// Uses a 4-bit retired counter so the wrap case is reachable quickly.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    wb_control_t      wb_ctrl_in;
    logic [4:0]       rd_addr_in;
    logic [31:0]      alu_result, pc_plus4, imm;
    logic [2:0]       fun3;
    logic [1:0]       addr_lo;
    logic             flush;
    logic             dmem_rvalid;
    logic [31:0]      dmem_rdata;
    logic             reg_write;
    logic [4:0]       rd_addr;
    logic [31:0]      rd_data;
    logic [CNT_W-1:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wb_ctrl_in    (wb_ctrl_in),
        .rd_addr_in    (rd_addr_in),
        .alu_result    (alu_result),
        .pc_plus4      (pc_plus4),
        .imm           (imm),
        .fun3          (fun3),
        .addr_lo       (addr_lo),
        .flush         (flush),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .reg_write     (reg_write),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one instruction for one clock, returns at the next negedge.
    task automatic issue(input mem_to_reg_e mtr, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] im,
                         input logic [2:0] f3, input logic [1:0] lo);
        wb_ctrl_in = '{mem_to_reg: mtr, reg_write: we};
        rd_addr_in = rd;
        alu_result = alu;
        pc_plus4   = pc4;
        imm        = im;
        fun3       = f3;
        addr_lo    = lo;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Pulses dmem_rvalid for one clock, returns at the following negedge.
    task automatic respond(input logic [31:0] data);
        dmem_rvalid = 1'b1;
        dmem_rdata  = data;
        @(posedge clk);
        @(negedge clk);
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; wb_ctrl_in = '{mem_to_reg: MTR_ALU, reg_write: 1'b0};
        rd_addr_in = '0; alu_result = '0; pc_plus4 = '0; imm = '0; fun3 = '0; addr_lo = '0;
        flush = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_in_ready", in_ready, 1);
        check("rst_reg_write", reg_write, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count", retired_count, 0);

        issue(MTR_ALU, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, F3_LW, 2'd0);
        check("alu_we", reg_write, 1);
        check("alu_rd", rd_addr, 5);
        check("alu_data", rd_data, 32'h0000_1234);
        check("alu_count", retired_count, 1);
        @(negedge clk);
        check("alu_pulse_end", reg_write, 0);
        check("alu_data_hold", rd_data, 32'h0000_1234);

        issue(MTR_PC4, 1'b1, 5'd3, 32'h1, 32'h0000_0104, 32'h2, F3_LW, 2'd0);
        check("pc4_data", rd_data, 32'h0000_0104);
        issue(MTR_IMM, 1'b1, 5'd4, 32'h1, 32'h2, 32'hABCD_0000, F3_LW, 2'd0);
        check("imm_data", rd_data, 32'hABCD_0000);
        check("imm_count", retired_count, 3);

        issue(MTR_PC4, 1'b1, 5'd0, 32'h0, 32'h0000_0104, 32'h0, F3_LW, 2'd0);
        check("x0_we", reg_write, 0);
        check("x0_count", retired_count, 3);
        check("x0_data_hold", rd_data, 32'hABCD_0000);

        issue(MTR_MEM, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, F3_LW, 2'd0);
        check("lw_ready0", in_ready, 0);
        check("lw_we0", reg_write, 0);
        repeat (2) @(negedge clk);
        check("lw_ready_wait", in_ready, 0);
        respond(32'hDEAD_BEEF);
        check("lw_we", reg_write, 1);
        check("lw_rd", rd_addr, 7);
        check("lw_data", rd_data, 32'hDEAD_BEEF);
        check("lw_ready1", in_ready, 1);
        check("lw_count", retired_count, 4);

        respond(32'h1111_1111);
        check("idle_rvalid_we", reg_write, 0);
        check("idle_rvalid_count", retired_count, 4);

        issue(MTR_MEM, 1'b1, 5'd8, 32'h0, 32'h0, 32'h0, F3_LW, 2'd0);
        flush = 1'b1;
        respond(32'h2222_2222);
        flush = 1'b0;
        check("flush_rv_we", reg_write, 0);
        check("flush_rv_ready", in_ready, 1);
        @(negedge clk);
        check("flush_rv_we_late", reg_write, 0);
        check("flush_rv_count", retired_count, 4);

        flush = 1'b1;
        issue(MTR_ALU, 1'b1, 5'd9, 32'h9999_9999, 32'h0, 32'h0, F3_LW, 2'd0);
        flush = 1'b0;
        check("flush_idle_we", reg_write, 0);
        check("flush_idle_rd", rd_addr, 7);
        check("flush_idle_ready", in_ready, 1);

        issue(MTR_ALU, 1'b1, 5'd10, 32'h0000_00AA, 32'h0, 32'h0, F3_LW, 2'd0);
        flush = 1'b1;
        check("flush_pulse_we", reg_write, 1);
        check("flush_pulse_rd", rd_addr, 10);
        check("flush_pulse_count", retired_count, 5);
        @(negedge clk);
        flush = 1'b0;

`ifdef LOAD_ALIGN_EN
        issue(MTR_MEM, 1'b1, 5'd12, 32'h0, 32'h0, 32'h0, F3_LB, 2'd3);
        respond(32'h8012_3456);
        check("lb_data", rd_data, 32'hFFFF_FF80);
        issue(MTR_MEM, 1'b1, 5'd13, 32'h0, 32'h0, 32'h0, F3_LHU, 2'd2);
        respond(32'hBEEF_0000);
        check("lhu_data", rd_data, 32'h0000_BEEF);
`endif

        issue(MTR_MEM, 1'b1, 5'd11, 32'h0, 32'h0, 32'h0, F3_LW, 2'd0);
        check("rst_mid_ready0", in_ready, 0);
        #2 reset = 1'b1;
        #1 check("rst_async_ready", in_ready, 1);
        check("rst_async_count", retired_count, 0);
        @(negedge clk);
        reset = 1'b0;
        respond(32'h3333_3333);
        check("rst_mid_we", reg_write, 0);
        check("rst_mid_rd", rd_addr, 0);
        check("rst_mid_data", rd_data, 0);
        check("rst_mid_count", retired_count, 0);

        for (int i = 0; i < 15; i++)
            issue(MTR_ALU, 1'b1, 5'd1, 32'(i), 32'h0, 32'h0, F3_LW, 2'd0);
        check("cnt_all_ones", retired_count, 4'hF);
        issue(MTR_ALU, 1'b1, 5'd1, 32'h55, 32'h0, 32'h0, F3_LW, 2'd0);
        check("cnt_wrap", retired_count, 0);
        check("cnt_wrap_we", reg_write, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
